shift_add_multiplier: RTL

Iterative unsigned WIDTH×WIDTH → 2·WIDTH multiplier built on the shift-and-add principle. Each cycle it forms one partial product, which is the multiplicand gated by the current multiplier bit: either the multiplicand or zero. It adds that partial product into the upper accumulator half and shifts the whole accumulator right. The block consumes one partial product per clock and exposes a start/busy/done handshake to the datapath controller above it.

---
 rtl/mul_pkg.sv | 17 +
 rtl/mul_datapath.sv | 54 +++++
 rtl/shift_add_multiplier.sv | 91 +++++++++
 3 files changed

// File: rtl/mul_pkg.sv
// Shared types and constants for the iterative shift-and-add multiplier.
package mul_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } mul_state_t;

    localparam int unsigned MUL_WIDTH = 32;

    // Bits needed to count 0 .. width-1; kept at least 1 so the counter is never zero-width.
    function automatic int unsigned cnt_width(input int unsigned width);
        return (width > 1) ? $clog2(width) : 1;
    endfunction

endpackage

// File: rtl/mul_datapath.sv
// Shift-and-add datapath: operand capture, accumulator with carry, and result register.
module mul_datapath #(
    parameter int unsigned Width = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               load_i,
    input  logic               step_i,
    input  logic               commit_i,
    input  logic [Width-1:0]   multiplicand_i,
    input  logic [Width-1:0]   multiplier_i,
    output logic [2*Width-1:0] product_o
);

    logic [Width-1:0]   mcand_q;
    logic [Width-1:0]   hi_q;
    logic [Width-1:0]   lo_q;
    logic [2*Width-1:0] product_q;

    logic [Width-1:0]   pp;
    logic [Width:0]     sum;
    logic [2*Width-1:0] shifted;

    // {carry, sum, lo} >> 1: the adder carry lands in the MSB of hi, nothing is lost.
    always_comb begin
        pp      = lo_q[0] ? mcand_q : '0;
        sum     = {1'b0, hi_q} + {1'b0, pp};
        shifted = {sum, lo_q[Width-1:1]};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mcand_q   <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            product_q <= '0;
        end else begin
            if (load_i) begin
                mcand_q <= multiplicand_i;
                hi_q    <= '0;
                lo_q    <= multiplier_i;
            end else if (step_i) begin
                hi_q <= shifted[2*Width-1:Width];
                lo_q <= shifted[Width-1:0];
            end
            if (commit_i) begin
                product_q <= shifted;
            end
        end
    end

    assign product_o = product_q;

endmodule

// File: rtl/shift_add_multiplier.sv
// Iterative unsigned WIDTH x WIDTH multiplier with start/busy/done handshake.
module shift_add_multiplier
    import mul_pkg::*;
#(
    parameter int unsigned WIDTH = MUL_WIDTH
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start_i,
    input  logic [WIDTH-1:0]   multiplicand_i,
    input  logic [WIDTH-1:0]   multiplier_i,
    output logic               ready_o,
    output logic               busy_o,
    output logic               done_o,
    output logic [2*WIDTH-1:0] product_o
);

    localparam int unsigned CntW = cnt_width(WIDTH);
    localparam logic [CntW-1:0] LastCount = CntW'(WIDTH - 1);

    mul_state_t      state_q;
    logic [CntW-1:0] count_q;
    logic            done_q;

    logic load;
    logic step;
    logic commit;

    // Start is only honoured outside RUN, so load and step never coincide.
    always_comb begin
        load   = (state_q != RUN) && start_i;
        step   = (state_q == RUN);
        commit = step && (count_q == LastCount);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            count_q <= '0;
            done_q  <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    done_q <= 1'b0;
                    if (start_i) begin
                        state_q <= RUN;
                        count_q <= '0;
                    end
                end
                RUN: begin
                    count_q <= count_q + CntW'(1);
                    if (count_q == LastCount) begin
                        state_q <= DONE;
                        done_q  <= 1'b1;
                    end
                end
                DONE: begin
                    done_q <= 1'b0;
                    if (start_i) begin
                        state_q <= RUN;
                        count_q <= '0;
                    end else begin
                        state_q <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    mul_datapath #(
        .Width (WIDTH)
    ) u_datapath (
        .clk            (clk),
        .rst_n          (rst_n),
        .load_i         (load),
        .step_i         (step),
        .commit_i       (commit),
        .multiplicand_i (multiplicand_i),
        .multiplier_i   (multiplier_i),
        .product_o      (product_o)
    );

    assign ready_o = (state_q != RUN);
    assign busy_o  = (state_q == RUN);
    assign done_o  = done_q;

endmodule
